// File: rtl/thermo_decoder_if.sv
// Handshake bundle for thermo_decoder: code input side, ramp select,
// and thermometer output side.
interface thermo_decoder_if;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_code;
    logic       ramp_en;
    logic       out_valid;
    logic       out_ready;
    logic [6:0] therm;
    logic [2:0] code_q;
    logic       ramp_wrap;

    modport master (
        output in_valid,
        output in_code,
        output ramp_en,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  therm,
        input  code_q,
        input  ramp_wrap
    );

    modport slave (
        input  in_valid,
        input  in_code,
        input  ramp_en,
        input  out_ready,
        output in_ready,
        output out_valid,
        output therm,
        output code_q,
        output ramp_wrap
    );
endinterface

// File: rtl/thermo_decoder.sv
// 3-bit binary to 7-bit thermometer decoder with a one-word output slot
// and an optional internal ramp generator as the code source.
module thermo_decoder #(
    parameter bit INV_IN   = 1'b0,
    parameter int RAMP_DIV = 4
) (
    input logic              clk,
    input logic              rst_n,
    thermo_decoder_if.slave  bus
);

    localparam logic [7:0] DIV_LAST = 8'(RAMP_DIV - 1);

    logic       valid_q, valid_d;
    logic [2:0] code_q, code_d;
    logic [6:0] therm_q, therm_d;
    logic       wrap_q, wrap_d;
    logic [7:0] div_q, div_d;
    logic [2:0] ramp_q, ramp_d;

    logic       slot_free;
    logic       in_ready;
    logic       dir_load;
    logic       ramp_term;
    logic       ramp_load;
    logic       load;
    logic [2:0] load_code;

    function automatic logic [6:0] decode(input logic [2:0] c);
        logic [6:0] t;
        unique case (c)
            3'd0: t = 7'b0000000;
            3'd1: t = 7'b0000001;
            3'd2: t = 7'b0000011;
            3'd3: t = 7'b0000111;
            3'd4: t = 7'b0001111;
            3'd5: t = 7'b0011111;
            3'd6: t = 7'b0111111;
            3'd7: t = 7'b1111111;
        endcase
        return t;
    endfunction

    // in_ready is gated by rst_n so nothing is accepted while held in reset
    assign slot_free = !valid_q || bus.out_ready;
    assign in_ready  = slot_free && !bus.ramp_en && rst_n;

    always_comb begin
        dir_load  = bus.in_valid && in_ready;
        ramp_term = bus.ramp_en && (div_q == DIV_LAST);
        ramp_load = ramp_term && slot_free;
        load      = ramp_load || dir_load;

        load_code = INV_IN ? ~bus.in_code : bus.in_code;
        if (ramp_load) begin
            load_code = ramp_q;
        end

        div_d  = div_q;
        ramp_d = ramp_q;
        if (!bus.ramp_en) begin
            div_d  = 8'd0;
            ramp_d = 3'd0;
        end else if (ramp_load) begin
            div_d  = 8'd0;
            ramp_d = ramp_q + 3'd1;
        end else if (!ramp_term) begin
            div_d  = div_q + 8'd1;
        end

        valid_d = valid_q;
        code_d  = code_q;
        therm_d = therm_q;
        if (load) begin
            valid_d = 1'b1;
            code_d  = load_code;
            therm_d = decode(load_code);
        end else if (valid_q && bus.out_ready) begin
            valid_d = 1'b0;
        end

        wrap_d = ramp_load && (ramp_q == 3'd7);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            code_q  <= 3'd0;
            therm_q <= 7'd0;
            wrap_q  <= 1'b0;
            div_q   <= 8'd0;
            ramp_q  <= 3'd0;
        end else begin
            valid_q <= valid_d;
            code_q  <= code_d;
            therm_q <= therm_d;
            wrap_q  <= wrap_d;
            div_q   <= div_d;
            ramp_q  <= ramp_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = valid_q;
    assign bus.code_q    = code_q;
    assign bus.therm     = therm_q;
    assign bus.ramp_wrap = wrap_q;

endmodule

// File: tb/tb_thermo_decoder.sv
// Bench for thermo_decoder: two instances (plain/div4 and inverted/div1)
// checked every cycle against a behavioural model plus directed literals.
module tb_thermo_decoder;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [2:0] in_code;
    logic       ramp_en;
    logic       out_ready;

    int checks = 0;
    int errors = 0;

    thermo_decoder_if ifa ();
    thermo_decoder_if ifb ();

    assign ifa.in_valid  = in_valid;
    assign ifa.in_code   = in_code;
    assign ifa.ramp_en   = ramp_en;
    assign ifa.out_ready = out_ready;
    assign ifb.in_valid  = in_valid;
    assign ifb.in_code   = in_code;
    assign ifb.ramp_en   = ramp_en;
    assign ifb.out_ready = out_ready;

    thermo_decoder #(.INV_IN(1'b0), .RAMP_DIV(4)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    thermo_decoder #(.INV_IN(1'b1), .RAMP_DIV(1)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] TBL [8] = '{7'b0000000, 7'b0000001, 7'b0000011, 7'b0000111,
                            7'b0001111, 7'b0011111, 7'b0111111, 7'b1111111};

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // behavioural model, index 0 = dut_a, 1 = dut_b
    int       MDIV [2] = '{4, 1};
    bit       MINV [2] = '{1'b0, 1'b1};
    bit       mv   [2];
    int       mc   [2];
    bit       mw   [2];
    int       mr   [2];
    int       mcnt [2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < 2; j++) begin
                mv[j] = 0; mc[j] = 0; mw[j] = 0; mr[j] = 0; mcnt[j] = 0;
            end
        end else begin
            for (int j = 0; j < 2; j++) begin
                bit free, loaded;
                int code;
                free   = !mv[j] || out_ready;
                loaded = 0;
                code   = 0;
                if (ramp_en) begin
                    if (mcnt[j] >= MDIV[j] - 1) begin
                        if (free) begin
                            loaded  = 1;
                            code    = mr[j];
                            mr[j]   = (mr[j] + 1) % 8;
                            mcnt[j] = 0;
                        end
                    end else begin
                        mcnt[j]++;
                    end
                end else begin
                    mr[j]   = 0;
                    mcnt[j] = 0;
                    if (in_valid && free) begin
                        loaded = 1;
                        code   = MINV[j] ? 7 - int'(in_code) : int'(in_code);
                    end
                end
                mw[j] = loaded && ramp_en && code == 7;
                if (loaded) begin
                    mv[j] = 1;
                    mc[j] = code;
                end else if (mv[j] && out_ready) begin
                    mv[j] = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int j = 0; j < 2; j++) begin
            int rdy;
            int ov, oc, ot, ow, oi;
            rdy = ((!mv[j] || out_ready) && !ramp_en && rst_n) ? 1 : 0;
            ov = (j == 0) ? int'(ifa.out_valid) : int'(ifb.out_valid);
            oc = (j == 0) ? int'(ifa.code_q)    : int'(ifb.code_q);
            ot = (j == 0) ? int'(ifa.therm)     : int'(ifb.therm);
            ow = (j == 0) ? int'(ifa.ramp_wrap) : int'(ifb.ramp_wrap);
            oi = (j == 0) ? int'(ifa.in_ready)  : int'(ifb.in_ready);
            chk($sformatf("m%0d.in_ready", j), oi, rdy);
            chk($sformatf("m%0d.out_valid", j), ov, int'(mv[j]));
            chk($sformatf("m%0d.ramp_wrap", j), ow, int'(mw[j]));
            if (mv[j]) begin
                chk($sformatf("m%0d.code_q", j), oc, mc[j]);
                chk($sformatf("m%0d.therm", j), ot, (1 << mc[j]) - 1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_first, n, wraps, found, t;
        int codes [9];
        int times [9];
        rst_n = 0; in_valid = 0; in_code = 0; ramp_en = 0; out_ready = 1;
        #12;
        chk("rst.out_valid", int'(ifa.out_valid), 0);
        chk("rst.therm", int'(ifa.therm), 0);
        chk("rst.in_ready", int'(ifa.in_ready), 0);
        tick();
        rst_n = 1;
        tick();

        for (int i = 0; i < 8; i++) begin
            in_valid = 1; in_code = 3'(i);
            tick();
            chk($sformatf("sweep%0d.therm", i), int'(ifa.therm), int'(TBL[i]));
            chk($sformatf("sweep%0d.valid", i), int'(ifa.out_valid), 1);
        end
        in_valid = 0;
        tick();

        in_valid = 1; in_code = 3'b010;
        tick();
        chk("inv.code_q", int'(ifb.code_q), 5);
        chk("inv.therm", int'(ifb.therm), int'(7'b0011111));
        in_valid = 0;
        tick();

        in_valid = 1; in_code = 3'd5;
        tick();
        out_ready = 0; in_code = 3'd2;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp.in_ready", int'(ifa.in_ready), 0);
            chk("bp.therm", int'(ifa.therm), int'(7'b0011111));
            tick();
        end
        chk("bp.hold", int'(ifa.therm), int'(7'b0011111));
        out_ready = 1;
        #1;
        chk("bp.release_ready", int'(ifa.in_ready), 1);
        tick();
        chk("bp.next", int'(ifa.therm), int'(7'b0000011));
        in_valid = 0;
        tick();

        ramp_en = 1;
        n = 0; wraps = 0;
        for (int k = 1; k <= 38; k++) begin
            tick();
            if (ifa.out_valid && n < 9) begin
                codes[n] = int'(ifa.code_q);
                times[n] = k;
                n++;
            end
            if (ifa.ramp_wrap) begin
                wraps++;
                chk("ramp.wrap_code", int'(ifa.code_q), 7);
            end
        end
        chk("ramp.count", n, 9);
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("ramp%0d.code", i), codes[i], i % 8);
            chk($sformatf("ramp%0d.time", i), times[i], 4 * (i + 1));
        end
        chk("ramp.wraps", wraps, 1);

        ramp_en = 0;
        tick();
        ramp_en = 1;
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            tick();
            if (ifa.out_valid && ifa.code_q == 3'd3) found = 1;
        end
        chk("stall.find3", found, 1);
        out_ready = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("stall.hold3", int'(ifa.code_q), 3);
        end
        out_ready = 1;
        tick();
        chk("stall.code4", int'(ifa.code_q), 4);
        chk("stall.valid4", int'(ifa.out_valid), 1);
        found = 0;
        for (int k = 0; k < 10 && !found; k++) begin
            tick();
            if (ifa.out_valid) found = 1;
        end
        chk("stall.found5", found, 1);
        chk("stall.code5", int'(ifa.code_q), 5);

        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            tick();
            if (ifa.out_valid && ifa.code_q == 3'd6) found = 1;
        end
        chk("arst.find6", found, 1);
        #2;
        rst_n = 0;
        #1;
        chk("arst.out_valid", int'(ifa.out_valid), 0);
        chk("arst.therm", int'(ifa.therm), 0);
        chk("arst.code_q", int'(ifa.code_q), 0);
        chk("arst.ramp_wrap", int'(ifa.ramp_wrap), 0);
        chk("arst.in_ready", int'(ifa.in_ready), 0);
        tick();
        tick();
        rst_n = 1;
        t_first = -1;
        t = 0;
        for (int k = 1; k <= 8 && t_first < 0; k++) begin
            tick();
            if (ifa.out_valid) begin
                t_first = k;
                t = int'(ifa.code_q);
            end
        end
        chk("arst.first_time", t_first, 4);
        chk("arst.first_code", t, 0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/thermo_decoder.md
THERMO_DECODER -- requirements
Module: thermo_decoder

Interface
REQ-001 The block SHALL provide parameter INV_IN, default 0, meaning: when 1, in_code is bitwise-inverted before decoding, for sources that deliver inverted-polarity codes.
REQ-002 The block SHALL provide parameter RAMP_DIV, default 4, meaning: clock cycles per ramp step; legal range 1..255.
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  in_code is valid this cycle.
REQ-006 in_ready  output  1  block accepts in_code this cycle.
REQ-007 in_code  input  3  binary code to decode.
REQ-008 ramp_en  input  1  selects the internal ramp generator as the code source instead of in_code.
REQ-009 out_valid  output  1  therm/code_q hold a valid word.
REQ-010 out_ready  input  1  downstream consumes the word this cycle.
REQ-011 therm  output  7  thermometer code; bit i = 1 iff code_q > i.
REQ-012 code_q  output  3  registered binary code, after any INV_IN inversion.
REQ-013 ramp_wrap  output  1  single-cycle pulse marking the load of ramp code 7.

Function
REQ-014 Output stage SHALL be one register slot; slot_free = !out_valid || out_ready.
REQ-015 Transfers: input on in_valid && in_ready; output on out_valid && out_ready.
REQ-016 in_ready SHALL equal slot_free && !ramp_en (combinational).
REQ-017 Direct mode (ramp_en=0): on an input transfer, code_q <= (INV_IN ? ~in_code : in_code), therm <= decode of that value, and out_valid <= 1 on the same edge; latency 1 cycle.
REQ-018 Decode table: 0->0000000, 1->0000001, 2->0000011, 3->0000111, 4->0001111, 5->0011111, 6->0111111, 7->1111111 (therm[6:0]).
REQ-019 An output transfer with no new load SHALL clear out_valid; a simultaneous output transfer and load SHALL leave out_valid=1 with the new word (full throughput, one word per cycle).
REQ-020 While out_valid=1 && out_ready=0, therm and code_q SHALL hold stable.
REQ-021 Ramp mode (ramp_en=1): a divider counts 0..RAMP_DIV-1; at terminal count with slot_free, the ramp value loads into code_q/therm (INV_IN not applied), out_valid <= 1, ramp value increments modulo 8, and the divider returns to 0.
REQ-022 At terminal count with slot not free, the divider and ramp value SHALL hold until slot_free (no code skipped).
REQ-023 ramp_wrap SHALL be 1 exactly in the cycle after ramp code 7 is loaded; ramp value wraps 7->0.
REQ-024 With RAMP_DIV=1, a word SHALL load every cycle in which slot_free=1.
REQ-025 ramp_en 1->0: divider and ramp value SHALL clear to 0 on the next edge; a word already in the slot SHALL remain until consumed.
REQ-026 ramp_en 0->1: the first ramp word is code 0, loaded RAMP_DIV cycles later, subject to slot_free.
REQ-027 ramp_en and in_valid both high: in_valid SHALL be ignored (in_ready=0).

Reset
REQ-028 rst_n low SHALL immediately force out_valid=0, therm=0000000, code_q=000, ramp_wrap=0, divider=0, ramp value=0.
REQ-029 Reset mid-transfer SHALL discard the slot word; the first action after release is a fresh load.
REQ-030 in_ready SHALL be 0 while rst_n=0.

Verification
REQ-031 Direct sweep, INV_IN=0, out_ready=1: in_code 0..7 on consecutive cycles -> therm per REQ-018 one cycle later, out_valid=1 continuously.
REQ-032 INV_IN=1: in_code=3'b010 -> code_q=101, therm=0011111.
REQ-033 Backpressure: load 5, hold out_ready=0 for 3 cycles with in_valid=1, in_code=2 -> in_ready=0, therm stays 0011111; on out_ready=1, next word 0000011.
REQ-034 Ramp, RAMP_DIV=4, out_ready=1: words 0,1,...,7,0 spaced 4 cycles apart; ramp_wrap pulses once, the cycle after code 7 loads.
REQ-035 Ramp stall: out_ready=0 for 10 cycles after code 3 -> codes 4,5 are not skipped once out_ready=1.
REQ-036 Assert rst_n=0 asynchronously mid-ramp at code 6 -> outputs zero immediately, before the next clk edge; after release with ramp_en=1, first word is 0.
